// File: rtl/memtest_pkg.sv
// Shared types and constants for the memory-tester serial reporter.
// Holds the FSM encoding, line layout constants and the hex helper.
package memtest_pkg;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    IDLE = 3'd1,
    SNAP = 3'd2,
    SEND = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } state_e;

  localparam int LINE_LEN = 23;
  localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);

  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_F  = 8'h46;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  function automatic logic [7:0] hex_char(
    input logic [3:0] n
  );
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/memtest_report_if.sv
// Status bus between the memory tester and the serial reporter.
// master = tester/bench side, slave = reporter side.
interface memtest_report_if;

  logic [31:0] passcount;
  logic [31:0] failcount;
  logic        force_report;
  logic        txd;
  logic        busy;
  logic [15:0] lines_sent;

  modport master (
    output passcount,
    output failcount,
    output force_report,
    input  txd,
    input  busy,
    input  lines_sent
  );

  modport slave (
    input  passcount,
    input  failcount,
    input  force_report,
    output txd,
    output busy,
    output lines_sent
  );

endinterface

// File: rtl/memtest_report_uart_tx.sv
// 8N1 UART transmitter with a start/ready handshake.
// The shift register LSB drives the pin, so reset forces txd high at once.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  shift_q, shift_d;
  logic        ready_q, ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      ready_q <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ready_d = ready_q;
    if (ready_q) begin
      if (start) begin
        shift_d = {1'b1, data, 1'b0};
        baud_d  = '0;
        bit_d   = '0;
        ready_d = 1'b0;
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_d  = '0;
      shift_d = {1'b1, shift_q[9:1]};
      if (bit_q == 4'd9) begin
        ready_d = 1'b1;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + 16'd1;
    end
  end

  assign ready = ready_q;
  assign txd   = shift_q[0];

endmodule

// File: rtl/memtest_report.sv
// Snapshots the tester pass/fail counters on change and sends
// one "P=xxxxxxxx F=xxxxxxxx\r\n" line per snapshot over UART.
module memtest_report #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] passcount,
  input  logic [31:0] failcount,
  input  logic        force_report,
  output logic        txd,
  output logic        busy,
  output logic [15:0] lines_sent
);

  import memtest_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] snap_pass_q, snap_pass_d;
  logic [31:0] snap_fail_q, snap_fail_d;
  logic [31:0] last_pass_q, last_pass_d;
  logic [31:0] last_fail_q, last_fail_d;
  logic        pending_q, pending_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] lines_sent_q, lines_sent_d;

  logic        trigger;
  logic        tx_start;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic [2:0]  pos_p;
  logic [2:0]  pos_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      snap_pass_q  <= '0;
      snap_fail_q  <= '0;
      last_pass_q  <= '0;
      last_fail_q  <= '0;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      lines_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      snap_pass_q  <= snap_pass_d;
      snap_fail_q  <= snap_fail_d;
      last_pass_q  <= last_pass_d;
      last_fail_q  <= last_fail_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      lines_sent_q <= lines_sent_d;
    end
  end

  assign trigger = pending_q | force_report
                 | (passcount != last_pass_q)
                 | (failcount != last_fail_q);

  always_comb begin
    state_d      = state_q;
    snap_pass_d  = snap_pass_q;
    snap_fail_d  = snap_fail_q;
    last_pass_d  = last_pass_q;
    last_fail_d  = last_fail_q;
    pending_d    = pending_q;
    idx_d        = idx_q;
    lines_sent_d = lines_sent_q;
    tx_start     = 1'b0;
    unique case (state_q)
      BOOT: state_d = SNAP;
      IDLE: if (trigger) state_d = SNAP;
      SNAP: begin
        snap_pass_d = passcount;
        snap_fail_d = failcount;
        last_pass_d = passcount;
        last_fail_d = failcount;
        pending_d   = 1'b0;
        idx_d       = '0;
        state_d     = SEND;
      end
      SEND: begin
        tx_start = 1'b1;
        if (tx_ready) state_d = WAIT;
      end
      WAIT: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = SEND;
          end
        end
      end
      DONE: begin
        lines_sent_d = lines_sent_q + 16'd1;
        state_d      = IDLE;
      end
      default: state_d = BOOT;
    endcase
    // A force seen during SNAP must survive the clear above
    if (force_report && state_q != IDLE) pending_d = 1'b1;
  end

  // Nibble slot within each hex field, MSB first (9-idx, 20-idx mod 8)
  assign pos_p = 3'd1 - idx_q[2:0];
  assign pos_f = 3'd4 - idx_q[2:0];

  always_comb begin
    tx_byte = CH_LF;
    unique case (1'b1)
      idx_q == 5'd0:
        tx_byte = CH_P;
      idx_q == 5'd1 || idx_q == 5'd12:
        tx_byte = CH_EQ;
      idx_q >= 5'd2 && idx_q <= 5'd9:
        tx_byte = hex_char(snap_pass_q[{pos_p, 2'b00} +: 4]);
      idx_q == 5'd10:
        tx_byte = CH_SP;
      idx_q == 5'd11:
        tx_byte = CH_F;
      idx_q >= 5'd13 && idx_q <= 5'd20:
        tx_byte = hex_char(snap_fail_q[{pos_f, 2'b00} +: 4]);
      idx_q == 5'd21:
        tx_byte = CH_CR;
      default:
        tx_byte = CH_LF;
    endcase
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .data  (tx_byte),
    .ready (tx_ready),
    .txd   (txd)
  );

  assign busy       = (state_q != BOOT) && (state_q != IDLE);
  assign lines_sent = lines_sent_q;

endmodule
